// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle RISC-V controller.
// The controller takes the master modport. The datapath or bench takes the slave modport.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);

  // Datapath to controller
  logic [31:0]      instr;
  logic             zero;
  logic             lt;
  logic             ltu;
  logic             mem_ready;

  // Controller to datapath
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_write;
  logic             mem_read;
  logic             adr_src;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       imm_src;
  logic [3:0]       alu_ctrl;

  // Status / debug
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, zero, lt, ltu, mem_ready,
    output pc_write, ir_write, reg_write, mem_write, mem_read, adr_src,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
           state, illegal, instret
  );

  modport slave (
    output instr, zero, lt, ltu, mem_ready,
    input  pc_write, ir_write, reg_write, mem_write, mem_read, adr_src,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
           state, illegal, instret
  );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32I-subset datapath.
// The state and the retired-instruction count are registered.
// Datapath strobes and selects are decoded from the current state, the IR and the ALU flags.
module multicycle_control #(
  parameter int unsigned FULL_BRANCH = 1,
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int          CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_PASSB = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;

  localparam bit FULL_BR = (FULL_BRANCH != 0);
  localparam bit MEM_WAIT = (MEM_WAIT_EN != 0);

  // Maps funct3/funct7[5] to an ALU operation.
  // Only R-type uses funct7[5] to pick sub.
  // Shifts use it to pick sra in both R-type and I-type.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7_5,
                                            input logic       is_r);
    case (f3)
      3'b000:  return (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       mem_rdy;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7_5 = bus.instr[30];

  // When memory waits are disabled, every access completes in one cycle.
  assign mem_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  // Branch condition and legality from funct3.
  // blt..bgeu are legal only with the full branch set.
  logic br_legal, br_taken;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    br_legal = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_legal = 1'b1;    br_taken = bus.zero;            end
      3'b001: begin br_legal = 1'b1;    br_taken = !bus.zero;           end
      3'b100: begin br_legal = FULL_BR; br_taken = FULL_BR && bus.lt;   end
      3'b101: begin br_legal = FULL_BR; br_taken = FULL_BR && !bus.lt;  end
      3'b110: begin br_legal = FULL_BR; br_taken = FULL_BR && bus.ltu;  end
      3'b111: begin br_legal = FULL_BR; br_taken = FULL_BR && !bus.ltu; end
      default: ;
    endcase
  end

  // Immediate format is decoded from the opcode in every state.
  // This lets the immediate generator settle before DECODE needs it.
  always_comb begin
    case (opcode)
      OP_LOAD, OP_ITYPE, OP_JALR: bus.imm_src = 3'b000;
      OP_STORE:                   bus.imm_src = 3'b001;
      OP_BRANCH:                  bus.imm_src = 3'b010;
      OP_JAL:                     bus.imm_src = 3'b011;
      OP_LUI:                     bus.imm_src = 3'b100;
      default:                    bus.imm_src = 3'b000;
    endcase
  end

  logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c, mem_read_c;
  logic       illegal_c, retire;
  logic       adr_src_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;
  logic [3:0] alu_ctrl_c;

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    adr_src_c    = 1'b0;
    illegal_c    = 1'b0;
    retire       = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    alu_ctrl_c   = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        pc_write_c  = mem_rdy;
        ir_write_c  = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Precompute the branch/jal target oldPC+imm into ALUOut.
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        adr_src_c  = 1'b1;
        mem_read_c = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src_c = RES_RDATA;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end

      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (mem_rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        alu_ctrl_c  = alu_decode(funct3, funct7_5, 1'b1);
        state_d     = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        alu_ctrl_c  = alu_decode(funct3, funct7_5, 1'b0);
        state_d     = S_ALUWB;
      end

      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end

      S_BRANCH: begin
        // Compare rs1-rs2. The target computed in DECODE waits in ALUOut.
        alu_src_a_c  = SRCA_RS1;
        alu_src_b_c  = SRCB_RS2;
        alu_ctrl_c   = ALU_SUB;
        result_src_c = RES_ALUOUT;
        pc_write_c   = br_legal && br_taken;
        illegal_c    = !br_legal;
        state_d      = S_FETCH;
        retire       = br_legal;
      end

      S_JALR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = S_JUMP;
      end

      S_JUMP: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4 for rd.
        pc_write_c   = 1'b1;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        state_d      = S_ALUWB;
      end

      S_LUI: begin
        alu_src_b_c = SRCB_IMM;
        alu_ctrl_c  = ALU_PASSB;
        state_d     = S_ALUWB;
      end

      default: state_d = S_FETCH;
    endcase

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // NOTE: strobes are ANDed with rst_n so they drop the moment reset asserts, even mid-wait, not at the next edge.
  assign bus.pc_write   = pc_write_c  & rst_n;
  assign bus.ir_write   = ir_write_c  & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.mem_write  = mem_write_c & rst_n;
  assign bus.mem_read   = mem_read_c  & rst_n;
  assign bus.illegal    = illegal_c   & rst_n;
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_ctrl   = alu_ctrl_c;
  assign bus.state      = state_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// dut0 uses the default parameters.
// dut1 uses FULL_BRANCH=0 and CNT_W=4, and both DUTs run in lockstep on the same inputs.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) if0 ();
  multicycle_control_if #(.CNT_W(4))  if1 ();

  assign if0.instr = instr;  assign if0.zero = zero;  assign if0.lt = lt;
  assign if0.ltu = ltu;      assign if0.mem_ready = mem_ready;
  assign if1.instr = instr;  assign if1.zero = zero;  assign if1.lt = lt;
  assign if1.ltu = ltu;      assign if1.mem_ready = mem_ready;

  multicycle_control #(.FULL_BRANCH(1), .MEM_WAIT_EN(1), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  multicycle_control #(.FULL_BRANCH(0), .MEM_WAIT_EN(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_LW    = 32'h00002103; // lw x2,0(x0)
  localparam logic [31:0] I_SW    = 32'h00202223; // sw x2,4(x0)
  localparam logic [31:0] I_BGE   = 32'h0020D463; // bge x1,x2,8
  localparam logic [31:0] I_BEQ   = 32'h00208463; // beq x1,x2,8
  localparam logic [31:0] I_BLTU  = 32'h0020E463; // bltu x1,x2,8
  localparam logic [31:0] I_BBAD  = 32'h0020A463; // branch funct3=010
  localparam logic [31:0] I_JALR  = 32'h000100E7; // jalr x1,0(x2)
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_SRAI  = 32'h4030D093; // srai x1,x1,3
  localparam logic [31:0] I_ADDM1 = 32'hFFF00093; // addi x1,x0,-1 (instr[30]=1)
  localparam logic [31:0] I_LUI   = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] I_JAL   = 32'h000000EF; // jal x1,0
  localparam logic [31:0] I_ZERO  = 32'h00000000; // undecodable

  // Flag sets {zero, lt, ltu, mem_ready}
  localparam logic [3:0] F_R   = 4'b0001;
  localparam logic [3:0] F_W   = 4'b0000;
  localparam logic [3:0] F_LT  = 4'b0101;
  localparam logic [3:0] F_Z   = 4'b1001;
  localparam logic [3:0] F_LTU = 4'b0011;

  // Expected bundle: {state, pcw,irw,rw,mw,mr,adr, res, a, b, imm, alu, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [23:0] exp;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t v(input logic [31:0] i, input logic [3:0] fl,
                             input logic [3:0] st, input logic [5:0] strb,
                             input logic [1:0] res, input logic [1:0] a,
                             input logic [1:0] b, input logic [2:0] imm,
                             input logic [3:0] alu, input logic ill,
                             input logic [31:0] cnt);
    vec_t r;
    r.instr = i;
    r.flags = fl;
    r.exp   = {st, strb, res, a, b, imm, alu, ill};
    r.cnt   = cnt;
    return r;
  endfunction

  function automatic vec_t vfetch(input logic [31:0] i, input logic [2:0] imm, input logic [31:0] c);
    return v(i, F_R, 4'd0, 6'b110010, 2'd0, 2'd0, 2'd2, imm, 4'd0, 1'b0, c);
  endfunction
  function automatic vec_t vdec(input logic [31:0] i, input logic [3:0] fl, input logic [2:0] imm, input logic [31:0] c);
    return v(i, fl, 4'd1, 6'b000000, 2'd0, 2'd1, 2'd1, imm, 4'd0, 1'b0, c);
  endfunction
  function automatic vec_t valuwb(input logic [31:0] i, input logic [2:0] imm, input logic [31:0] c);
    return v(i, F_R, 4'd8, 6'b001000, 2'd0, 2'd0, 2'd0, imm, 4'd0, 1'b0, c);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [3:0] fl);
    instr = i;
    {zero, lt, ltu, mem_ready} = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset across an edge, checks the reset state, and releases mid-cycle.
  // The following edge is then the first one evaluated with rst_n=1.
  task automatic apply_reset();
    rst_n = 1'b0;
    drive(I_ADDI, F_R);
    @(posedge clk);
    #1;
    check("rst_state",    64'(if0.state), 64'd0);
    check("rst_instret",  64'(if0.instret), 64'd0);
    check("rst_strobes",  64'({if0.pc_write, if0.ir_write, if0.mem_read, if1.mem_read}), 64'd0);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [23:0] act0();
    return {if0.state, if0.pc_write, if0.ir_write, if0.reg_write, if0.mem_write,
            if0.mem_read, if0.adr_src, if0.result_src, if0.alu_src_a, if0.alu_src_b,
            if0.imm_src, if0.alu_ctrl, if0.illegal};
  endfunction

  vec_t tbl[$];

  initial begin
    // ---- table ----
    // addi
    tbl.push_back(vfetch(I_ADDI, 3'd0, 0));
    tbl.push_back(vdec(I_ADDI, F_R, 3'd0, 0));
    tbl.push_back(v(I_ADDI, F_R, 4'd7, 6'b000000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 1'b0, 0));
    tbl.push_back(valuwb(I_ADDI, 3'd0, 0));
    // lw with one FETCH stall and three MEMREAD wait cycles
    tbl.push_back(v(I_LW, F_W, 4'd0, 6'b000010, 2'd0, 2'd0, 2'd2, 3'd0, 4'd0, 1'b0, 1));
    tbl.push_back(vfetch(I_LW, 3'd0, 1));
    tbl.push_back(vdec(I_LW, F_R, 3'd0, 1));
    tbl.push_back(v(I_LW, F_R, 4'd2, 6'b000000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 1'b0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(I_LW, F_W, 4'd3, 6'b000011, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, 1));
    tbl.push_back(v(I_LW, F_R, 4'd3, 6'b000011, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, 1));
    tbl.push_back(v(I_LW, F_R, 4'd4, 6'b001000, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0, 1));
    // sw with one wait cycle
    tbl.push_back(vfetch(I_SW, 3'd1, 2));
    tbl.push_back(vdec(I_SW, F_R, 3'd1, 2));
    tbl.push_back(v(I_SW, F_R, 4'd2, 6'b000000, 2'd0, 2'd2, 2'd1, 3'd1, 4'd0, 1'b0, 2));
    tbl.push_back(v(I_SW, F_W, 4'd5, 6'b000101, 2'd0, 2'd0, 2'd0, 3'd1, 4'd0, 1'b0, 2));
    tbl.push_back(v(I_SW, F_R, 4'd5, 6'b000101, 2'd0, 2'd0, 2'd0, 3'd1, 4'd0, 1'b0, 2));
    // bge lt=0 taken
    tbl.push_back(vfetch(I_BGE, 3'd2, 3));
    tbl.push_back(vdec(I_BGE, F_R, 3'd2, 3));
    tbl.push_back(v(I_BGE, F_R, 4'd9, 6'b100000, 2'd0, 2'd2, 2'd0, 3'd2, 4'd1, 1'b0, 3));
    // bge lt=1 not taken
    tbl.push_back(v(I_BGE, F_LT, 4'd0, 6'b110010, 2'd0, 2'd0, 2'd2, 3'd2, 4'd0, 1'b0, 4));
    tbl.push_back(vdec(I_BGE, F_LT, 3'd2, 4));
    tbl.push_back(v(I_BGE, F_LT, 4'd9, 6'b000000, 2'd0, 2'd2, 2'd0, 3'd2, 4'd1, 1'b0, 4));
    // beq zero=1 taken
    tbl.push_back(v(I_BEQ, F_Z, 4'd0, 6'b110010, 2'd0, 2'd0, 2'd2, 3'd2, 4'd0, 1'b0, 5));
    tbl.push_back(vdec(I_BEQ, F_Z, 3'd2, 5));
    tbl.push_back(v(I_BEQ, F_Z, 4'd9, 6'b100000, 2'd0, 2'd2, 2'd0, 3'd2, 4'd1, 1'b0, 5));
    // bltu ltu=1 taken
    tbl.push_back(v(I_BLTU, F_LTU, 4'd0, 6'b110010, 2'd0, 2'd0, 2'd2, 3'd2, 4'd0, 1'b0, 6));
    tbl.push_back(vdec(I_BLTU, F_LTU, 3'd2, 6));
    tbl.push_back(v(I_BLTU, F_LTU, 4'd9, 6'b100000, 2'd0, 2'd2, 2'd0, 3'd2, 4'd1, 1'b0, 6));
    // funct3=010 branch: not taken even with zero=1, illegal, not counted
    tbl.push_back(v(I_BBAD, F_Z, 4'd0, 6'b110010, 2'd0, 2'd0, 2'd2, 3'd2, 4'd0, 1'b0, 7));
    tbl.push_back(vdec(I_BBAD, F_Z, 3'd2, 7));
    tbl.push_back(v(I_BBAD, F_Z, 4'd9, 6'b000000, 2'd0, 2'd2, 2'd0, 3'd2, 4'd1, 1'b1, 7));
    // jalr
    tbl.push_back(vfetch(I_JALR, 3'd0, 7));
    tbl.push_back(vdec(I_JALR, F_R, 3'd0, 7));
    tbl.push_back(v(I_JALR, F_R, 4'd11, 6'b000000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 1'b0, 7));
    tbl.push_back(v(I_JALR, F_R, 4'd10, 6'b100000, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0, 1'b0, 7));
    tbl.push_back(valuwb(I_JALR, 3'd0, 7));
    // sub
    tbl.push_back(vfetch(I_SUB, 3'd0, 8));
    tbl.push_back(vdec(I_SUB, F_R, 3'd0, 8));
    tbl.push_back(v(I_SUB, F_R, 4'd6, 6'b000000, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1, 1'b0, 8));
    tbl.push_back(valuwb(I_SUB, 3'd0, 8));
    // srai -> sra
    tbl.push_back(vfetch(I_SRAI, 3'd0, 9));
    tbl.push_back(vdec(I_SRAI, F_R, 3'd0, 9));
    tbl.push_back(v(I_SRAI, F_R, 4'd7, 6'b000000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd9, 1'b0, 9));
    tbl.push_back(valuwb(I_SRAI, 3'd0, 9));
    // addi -1 with instr[30]=1 stays add
    tbl.push_back(vfetch(I_ADDM1, 3'd0, 10));
    tbl.push_back(vdec(I_ADDM1, F_R, 3'd0, 10));
    tbl.push_back(v(I_ADDM1, F_R, 4'd7, 6'b000000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 1'b0, 10));
    tbl.push_back(valuwb(I_ADDM1, 3'd0, 10));
    // lui
    tbl.push_back(vfetch(I_LUI, 3'd4, 11));
    tbl.push_back(vdec(I_LUI, F_R, 3'd4, 11));
    tbl.push_back(v(I_LUI, F_R, 4'd12, 6'b000000, 2'd0, 2'd0, 2'd1, 3'd4, 4'd6, 1'b0, 11));
    tbl.push_back(valuwb(I_LUI, 3'd4, 11));
    // jal
    tbl.push_back(vfetch(I_JAL, 3'd3, 12));
    tbl.push_back(vdec(I_JAL, F_R, 3'd3, 12));
    tbl.push_back(v(I_JAL, F_R, 4'd10, 6'b100000, 2'd0, 2'd1, 2'd2, 3'd3, 4'd0, 1'b0, 12));
    tbl.push_back(valuwb(I_JAL, 3'd3, 12));
    // undecodable opcode
    tbl.push_back(vfetch(I_ZERO, 3'd0, 13));
    tbl.push_back(v(I_ZERO, F_R, 4'd1, 6'b000000, 2'd0, 2'd1, 2'd1, 3'd0, 4'd0, 1'b1, 13));
    tbl.push_back(vfetch(I_ZERO, 3'd0, 13));

    apply_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].instr, tbl[i].flags);
      @(negedge clk);
      check($sformatf("row%0d_outputs", i), 64'(act0()), 64'(tbl[i].exp));
      check($sformatf("row%0d_instret", i), 64'(if0.instret), 64'(tbl[i].cnt));
      tick();
    end

    // ---- bge with lt=0: full-branch vs beq/bne-only ----
    apply_reset();
    drive(I_BGE, F_R);
    tick(); tick();                       // FETCH -> DECODE -> BRANCH
    @(negedge clk);
    check("bge_full_pcw",    64'(if0.pc_write), 64'd1);
    check("bge_full_ill",    64'(if0.illegal),  64'd0);
    check("bge_lite_pcw",    64'(if1.pc_write), 64'd0);
    check("bge_lite_ill",    64'(if1.illegal),  64'd1);
    tick();
    @(negedge clk);
    check("bge_lite_ill_one_cycle", 64'(if1.illegal), 64'd0);
    check("bge_full_retired", 64'(if0.instret), 64'd1);
    check("bge_lite_not_retired", 64'(if1.instret), 64'd0);
    tick();

    // ---- 16 addi: 4-bit counter wraps 15 -> 0, then illegal opcode ----
    apply_reset();
    drive(I_ADDI, F_R);
    for (int k = 0; k < 16; k++) begin
      repeat (4) tick();
      if (k == 14) begin
        @(negedge clk);
        check("wrap_cnt15", 64'(if1.instret), 64'd15);
      end
    end
    @(negedge clk);
    check("wrap_cnt0",     64'(if1.instret), 64'd0);
    check("wrap_full_cnt", 64'(if0.instret), 64'd16);
    drive(I_ZERO, F_R);
    tick();                               // DECODE
    @(negedge clk);
    check("illop_pulse", 64'({if0.illegal, if1.illegal}), 64'b11);
    tick();
    @(negedge clk);
    check("illop_state",  64'(if0.state), 64'd0);
    check("illop_clear",  64'({if0.illegal, if1.illegal}), 64'b00);
    check("illop_nocnt",  64'(if1.instret), 64'd0);
    check("illop_nocnt_full", 64'(if0.instret), 64'd16);
    tick();

    // ---- reset dropped mid MEMWRITE wait ----
    apply_reset();
    drive(I_ADDI, F_R);
    repeat (4) tick();
    drive(I_SW, F_R);
    repeat (3) tick();                    // FETCH, DECODE, MEMADR -> MEMWRITE
    drive(I_SW, F_W);
    @(negedge clk);
    check("sw_wait_state", 64'(if0.state), 64'd5);
    check("sw_wait_mw",    64'(if0.mem_write), 64'd1);
    check("sw_pre_cnt",    64'(if0.instret), 64'd1);
    tick();                               // still waiting, posedge+1
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_mw",     64'(if0.mem_write), 64'd0);
    check("rstmid_state",  64'(if0.state), 64'd0);
    check("rstmid_cnt",    64'(if0.instret), 64'd0);
    check("rstmid_mr",     64'(if0.mem_read), 64'd0);
    #1 rst_n = 1'b1;                      // released before the next edge
    drive(I_ADDI, F_R);
    @(negedge clk);
    check("post_rst_fetch", 64'({if0.mem_read, if0.ir_write, if0.pc_write}), 64'b111);
    tick();
    check("post_rst_decode", 64'(if0.state), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
